alu_share_arb: RTL and testbench



---
 rtl/alu_share_arb.sv | 116 +++++++++++
 tb/tb_alu_share_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// Ports: req0/req1 valid/ready request channels (a, b, sel operands),
//   resp0/resp1 valid/ready response channels with shared resp_res,
//   alu_a/alu_b/alu_sel/alu_res toward the ALU, busy and owner status.
// Optional macro ALU_ARB_RR_EN: round-robin tie-break instead of
//   fixed priority to port 0.
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_sel,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_res,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    output logic             busy,
    output logic             owner
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_sel;
    logic             pick1;
    logic             grant0;
    logic             grant1;
    logic             resp_done;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // On a tie, the port that did not win last time is served.
    always_comb begin
        pick1 = req1_valid & (~req0_valid | ~last_grant);
    end
`else
    always_comb begin
        pick1 = req1_valid & ~req0_valid;
    end
`endif

    always_comb begin
        grant1    = (state == IDLE) & pick1;
        grant0    = (state == IDLE) & req0_valid & ~pick1;
        resp_done = owner ? resp1_ready : resp0_ready;
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign resp0_valid = (state == RESP) & ~owner;
    assign resp1_valid = (state == RESP) & owner;
    assign busy        = (state != IDLE);
    // ALU inputs come straight from registers so they never glitch.
    assign alu_a       = op_a;
    assign alu_b       = op_b;
    assign alu_sel     = op_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            owner    <= 1'b0;
            resp_res <= '0;
`ifdef ALU_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        op_a   <= grant1 ? req1_a : req0_a;
                        op_b   <= grant1 ? req1_b : req0_b;
                        op_sel <= grant1 ? req1_sel : req0_sel;
                        owner  <= grant1;
`ifdef ALU_ARB_RR_EN
                        last_grant <= grant1;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    resp_res <= alu_res;
                    state    <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb with a small
// behavioural ALU; covers reset, add, backpressure, abort, ties.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [31:0] resp_res, alu_a, alu_b, alu_res;
    logic [3:0]  alu_sel;
    logic        busy, owner;

    int checks = 0;
    int failures = 0;
    int g0 = 0;
    int g1 = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_res(resp_res),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_res(alu_res),
        .busy(busy), .owner(owner)
    );

    always_comb begin
        alu_res = '0;
        case (alu_sel)
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a - alu_b;
            4'd6:    alu_res = alu_a ^ alu_b;
            4'd10:   alu_res = alu_a << alu_b[4:0];
            default: alu_res = alu_a & alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_a = 0; req1_b = 0; req1_sel = 0;
        resp0_ready = 0; resp1_ready = 0;

        // reset state
        nxt();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_res", resp_res, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_r0v", resp0_valid, 0);
        chk("rst_r1v", resp1_valid, 0);
        chk("rst_q0r", req0_ready, 0);
        chk("rst_q1r", req1_ready, 0);
        rst = 1'b0;
        nxt();

        // single add on port 0
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_sel = 0;
        #1;
        chk("add_q0r", req0_ready, 1);
        chk("add_q1r", req1_ready, 0);
        nxt();
        req0_valid = 0; req0_a = 32'hdead; req0_b = 32'hbeef;
        #1;
        chk("add_exec_busy", busy, 1);
        chk("add_exec_alu_a", alu_a, 5);
        chk("add_exec_alu_b", alu_b, 7);
        chk("add_exec_r0v", resp0_valid, 0);
        nxt();
        chk("add_r0v", resp0_valid, 1);
        chk("add_r1v", resp1_valid, 0);
        chk("add_res", resp_res, 12);
        resp0_ready = 1;
        nxt();
        resp0_ready = 0;
        chk("add_idle_busy", busy, 0);
        chk("add_idle_r0v", resp0_valid, 0);

        // backpressure on port 1, port 0 waiting meanwhile
        req1_valid = 1; req1_a = 1; req1_b = 4; req1_sel = 10;
        #1;
        chk("bp_q1r", req1_ready, 1);
        nxt();
        req1_valid = 0;
        req0_valid = 1; req0_a = 2; req0_b = 3; req0_sel = 0;
        #1;
        chk("bp_exec_q0r", req0_ready, 0);
        chk("bp_exec_owner", owner, 1);
        resp0_ready = 1;
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("bp_r1v", resp1_valid, 1);
            chk("bp_r0v", resp0_valid, 0);
            chk("bp_res", resp_res, 16);
            chk("bp_q0r", req0_ready, 0);
            chk("bp_q1r0", req1_ready, 0);
        end
        resp0_ready = 0;
        resp1_ready = 1;
        #1;
        chk("bp_rel_q0r", req0_ready, 0);
        nxt();
        resp1_ready = 0;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_r1v", resp1_valid, 0);
        chk("bp_idle_q0r", req0_ready, 1);
        nxt();
        req0_valid = 0;
        nxt();
        chk("bp_p0_res", resp_res, 5);
        chk("bp_p0_r0v", resp0_valid, 1);
        resp0_ready = 1;
        nxt();
        resp0_ready = 0;

        // reset during EXEC
        req1_valid = 1; req1_a = 9; req1_b = 1; req1_sel = 0;
        nxt();
        req1_valid = 0;
        chk("ab_exec_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_owner", owner, 0);
        chk("ab_alu_a", alu_a, 0);
        chk("ab_alu_b", alu_b, 0);
        chk("ab_res", resp_res, 0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("ab_r1v", resp1_valid, 0);
        end

        // tie straight out of reset
        req0_valid = 1; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
        req0_sel = 6;
        req1_valid = 1; req1_a = 10; req1_b = 3; req1_sel = 1;
        rst = 1'b0;
        #1;
        chk("tie_q0r", req0_ready, 1);
        chk("tie_q1r", req1_ready, 0);
        nxt();
        chk("tie_exec_r1v", resp1_valid, 0);
        nxt();
        chk("tie_r0v", resp0_valid, 1);
        chk("tie_res0", resp_res, 32'hFF00);
        resp0_ready = 1;
        nxt();
        resp0_ready = 0;
`ifdef ALU_ARB_RR_EN
        chk("rr_q1r", req1_ready, 1);
        chk("rr_q0r", req0_ready, 0);
        nxt();
        nxt();
        chk("rr_r1v", resp1_valid, 1);
        chk("rr_res1", resp_res, 7);
        resp1_ready = 1;
        nxt();
        resp1_ready = 0;
        chk("rr_again_q0r", req0_ready, 1);
        resp0_ready = 1; resp1_ready = 1;
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (req0_ready) g0++;
            if (req1_ready) g1++;
        end
        chk("rr_g0", (g0 >= 3) ? 32'd1 : 32'd0, 1);
        chk("rr_g1", (g1 >= 3) ? 32'd1 : 32'd0, 1);
`else
        chk("fx_q0r", req0_ready, 1);
        chk("fx_q1r", req1_ready, 0);
        resp0_ready = 1; resp1_ready = 1;
        for (int i = 0; i < 20; i++) begin
            nxt();
            chk("fx_starve_q1r", req1_ready, 0);
            chk("fx_starve_r1v", resp1_valid, 0);
            if (req0_ready) g0++;
        end
        chk("fx_g0", (g0 >= 5) ? 32'd1 : 32'd0, 1);
`endif
        req0_valid = 0; req1_valid = 0;
        resp0_ready = 0; resp1_ready = 0;
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
